// File: rtl/lsu_req_ctrl.sv
// Load/store request controller for port 2 of the word-organised data bank.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned halfword and word accesses fault.
module lsu_req_ctrl #(
  parameter int unsigned MEMSIZE = 16384,
  parameter int unsigned ADDRBIT = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [2:0]         i_req_funct3,
  input  logic [31:0]        i_req_addr,
  input  logic [31:0]        i_req_wdata,
  output logic               o_rsp_valid,
  output logic [31:0]        o_rsp_rdata,
  output logic               o_rsp_err,
  output logic [ADDRBIT-3:0] o_mem_addr,
  input  logic [31:0]        i_mem_rdata,
  output logic [31:0]        o_mem_wdata,
  output logic               o_mem_wren
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e             state_q, state_d;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [ADDRBIT-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        word_q;
  logic               err_q;

  logic               accept;
  logic               out_of_range;
  logic               funct3_bad;
  logic               misalign;
  logic               req_fault;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_data;
  logic [31:0]        merged;

  assign accept = (state_q == StIdle) && i_req_valid;

  // Request fault decode, evaluated on the live request at acceptance
  always_comb begin
    out_of_range = (i_req_addr >= 32'(MEMSIZE));
    if (i_req_we) begin
      funct3_bad = i_req_funct3[2] || (i_req_funct3 == 3'b011);
    end else begin
      funct3_bad = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                   (i_req_funct3 == 3'b111);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
               ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_fault = out_of_range || funct3_bad || misalign;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          if (req_fault) begin
            state_d = StResp;
          end else if (i_req_we && (i_req_funct3 == 3'b010)) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = we_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= i_req_we;
        funct3_q <= i_req_funct3;
        addr_q   <= i_req_addr[ADDRBIT-1:0];
        wdata_q  <= i_req_wdata;
        err_q    <= req_fault;
      end
      if (state_q == StRead) begin
        word_q <= i_mem_rdata;
      end
    end
  end

  // Lane selection ignores the low address bits a halfword/word does not use,
  // which force-aligns misaligned accesses when they are not trapped.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = word_q[7:0];
      2'b01:   ld_byte = word_q[15:8];
      2'b10:   ld_byte = word_q[23:16];
      default: ld_byte = word_q[31:24];
    endcase
    ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = word_q;
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = 32'h0000_0000;
    endcase
  end

  always_comb begin
    merged = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    o_req_ready = (state_q == StIdle);
    o_rsp_valid = (state_q == StResp);
    o_rsp_err   = (state_q == StResp) && err_q;
    o_rsp_rdata = ((state_q == StResp) && !err_q && !we_q) ? ld_data : 32'h0000_0000;
    o_mem_addr  = addr_q[ADDRBIT-1:2];
    // Reset in the WRITE cycle must suppress the write at that very edge
    o_mem_wren  = (state_q == StWrite) && !i_rst;
    o_mem_wdata = (state_q == StWrite) ? merged : 32'h0000_0000;
  end

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Scoreboard bench for lsu_req_ctrl: randomized requests against a byte-level reference model.
module tb_lsu_req_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [11:0] o_mem_addr;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_mem_wdata;
  logic        o_mem_wren;

  lsu_req_ctrl #(
    .MEMSIZE(16384),
    .ADDRBIT(14)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_funct3(i_req_funct3),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_mem_addr  (o_mem_addr),
    .i_mem_rdata (i_mem_rdata),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wren  (o_mem_wren)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          writes;
    int          acc;
  } exp_t;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        preload = 1'b0;
  exp_t        exp_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  int          wren_cnt = 0;

  assign i_mem_rdata = mem[o_mem_addr];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
    end else if (o_mem_wren) begin
      mem[o_mem_addr] <= o_mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: byte/halfword arithmetic on a word array, straight from the access rules
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int acc);
    exp_t        e;
    logic [31:0] old, b, h;
    int          w, sh;
    bit          fault;
    fault = (addr >= 32'd16384);
    if (we) fault = fault || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else fault = fault || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) fault = 1'b1;
    if (f3 == 3'd2 && (addr % 4) != 0) fault = 1'b1;
`endif
    e.acc    = acc;
    e.err    = fault;
    e.rdata  = 32'h0;
    e.writes = 0;
    e.lat    = 1;
    if (fault) return e;
    w   = int'(addr / 4);
    old = ref_mem[w];
    if (!we) begin
      e.lat = 2;
      b = (old >> (8 * (addr % 4))) & 32'hFF;
      h = (old >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      case (f3)
        3'd0:    e.rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd1:    e.rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'd2:    e.rdata = old;
        3'd4:    e.rdata = b;
        default: e.rdata = h;
      endcase
    end else begin
      e.writes = 1;
      e.lat    = (f3 == 3'd2) ? 2 : 3;
      case (f3)
        3'd0: begin
          sh = 8 * int'(addr % 4);
          ref_mem[w] = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end
        3'd1: begin
          sh = 16 * int'((addr / 2) % 2);
          ref_mem[w] = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        default: ref_mem[w] = wd;
      endcase
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a response strobe appears
  always @(negedge i_clk) begin
    if (i_rst) begin
      wren_cnt = 0;
    end else begin
      if (o_mem_wren) wren_cnt++;
      else check("wdata_idle_zero", o_mem_wdata, 32'h0);
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_err", 32'(o_rsp_err), 32'(e.err));
          check("rsp_rdata", o_rsp_rdata, e.rdata);
          check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          check("write_count", 32'(wren_cnt), 32'(e.writes));
          check("ready_in_resp", 32'(o_req_ready), 32'h0);
        end
        wren_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while (!o_req_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      tests++;
      failed++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit push);
    wait_idle();
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    if (push) exp_q.push_back(model(we, f3, addr, wd, cyc));
    @(negedge i_clk);
    // Scramble the request bus: it must only be sampled at acceptance
    i_req_valid  = 1'b0;
    i_req_we     = 1'($urandom);
    i_req_funct3 = 3'($urandom);
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int          r;
    logic [2:0]  f3_tab [0:4];
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;

    i_rst        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'h0;
    i_req_wdata  = 32'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[5] = 32'h8899AABB;
    preload    = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    preload = 1'b0;
    i_rst   = 1'b0;

    check("reset_ready", 32'(o_req_ready), 32'h1);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'h0);
    check("reset_rsp_err", 32'(o_rsp_err), 32'h0);
    check("reset_rsp_rdata", o_rsp_rdata, 32'h0);
    check("reset_wren", 32'(o_mem_wren), 32'h0);
    check("reset_mem_addr", 32'(o_mem_addr), 32'h0);
    check("reset_mem_wdata", o_mem_wdata, 32'h0);

    issue(1'b0, 3'd0, 32'h16, 32'h0, 1'b1);               // LB  -> FFFFFF99
    issue(1'b0, 3'd4, 32'h16, 32'h0, 1'b1);               // LBU -> 00000099
    issue(1'b1, 3'd0, 32'h15, 32'h11, 1'b1);              // SB
    wait_idle();
    check("sb_word5", mem[5], 32'h889911BB);
    issue(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 1'b1);        // SW
    issue(1'b0, 3'd1, 32'h22, 32'h0, 1'b1);               // LH  -> FFFFDEAD
    wait_idle();
    check("sw_word8", mem[8], 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h00004000, 32'h0, 1'b1);         // out of range
    issue(1'b0, 3'd1, 32'h13, 32'h0, 1'b1);               // misaligned LH
    issue(1'b1, 3'd3, 32'h08, 32'h12345678, 1'b1);        // undefined store funct3

    // Reset during the WRITE cycle of an SB: no write, no response
    issue(1'b1, 3'd0, 32'h24, 32'h5A, 1'b0);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("post_rst_ready", 32'(o_req_ready), 32'h1);
      check("post_rst_no_rsp", 32'(o_rsp_valid), 32'h0);
    end
    check("rst_write_suppressed", mem[9], ref_mem[9]);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 88) addr = 32'($urandom_range(0, 63));
      else if (r < 94) addr = 32'h4000 + 32'($urandom_range(0, 63));
      else addr = $urandom;
      if ($urandom_range(0, 99) < 80) f3 = f3_tab[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), f3, addr, $urandom, 1'b1);
    end

    wait_idle();
    repeat (2) @(negedge i_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lsu_req_ctrl.md
# lsu_req_ctrl

Load/store front-end between the execute stage and port 2 of the word-organised data bank. Accepts one byte, halfword or word request at a time over a valid/ready handshake, and turns sub-word stores into a read-modify-write sequence. Applies sign or zero extension to loads and returns each result or error on a single-cycle response strobe. Drives the bank's word address, write data and write enable, and reads its combinational read data.

## Interface
- `MEMSIZE`, 16384: data memory size in bytes (power of two).
- `ADDRBIT`, 14: byte-address bits covering `MEMSIZE`. The word address is `[ADDRBIT-1:2]`.
- `i_clk` in 1: the only clock.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: controller can accept a request.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_funct3` in 3: RV32I width code.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- `i_req_addr` in 32: byte address.
- `i_req_wdata` in 32: store data, right-aligned.
- `o_rsp_valid` out 1: one-cycle completion strobe.
- `o_rsp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `o_rsp_err` out 1: access fault, qualified by `o_rsp_valid`.
- `o_mem_addr` out ADDRBIT-2: word address to the bank.
- `i_mem_rdata` in 32: bank read data, combinational from `o_mem_addr`.
- `o_mem_wdata` out 32: bank write data.
- `o_mem_wren` out 1: bank write enable.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE
  - `o_req_ready`=1.
  - On `i_req_valid`, latch we, funct3, addr and wdata, then branch:
    - fault → RESP with err=1;
    - load or SB/SH → READ;
    - SW → WRITE.
- READ
  - `o_mem_addr` = latched `addr[ADDRBIT-1:2]`.
  - Capture `i_mem_rdata` into the word register.
  - Load → RESP. Store → WRITE.
- WRITE
  - `o_mem_wren`=1 and `o_mem_wdata` = merged word.
  - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`.
  - SH replaces lanes `{addr[1],0}` and `{addr[1],1}` with `wdata[15:0]`.
  - SW writes `wdata` unchanged.
  - Next state is RESP.
- RESP
  - `o_rsp_valid`=1 for exactly one cycle, then IDLE.
  - There is no response backpressure.
  - `o_req_ready`=0 in every state except IDLE.
- Load extraction from the captured word:
  - byte lane selected by `addr[1:0]`; halfword lane selected by `addr[1]`;
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Faults (err=1, no memory write):
  - `addr[31:ADDRBIT]` != 0;
  - funct3 is undefined for the direction (load 011/110/111, store 1xx or 011);
  - misalignment, per Configuration.
- `o_mem_addr` holds the latched word address in all states.
- `o_mem_wdata` equals the merged word in WRITE and 0 otherwise.

## Timing
- A request is accepted at rising edge T when `i_req_valid`=1 and the state is IDLE.
- Completion latency (`o_rsp_valid` high):
  - load: cycle T+2;
  - SW: T+2, write at edge T+2;
  - SB/SH: T+3, read in T+1, write at edge T+3;
  - fault: T+1.
- The next request can be accepted in the cycle after RESP. Sustained throughput is one load per 3 cycles.
- Reset values:
  - state IDLE;
  - all latched fields and the word register 0;
  - `o_req_ready`=1;
  - `o_rsp_valid`=0, `o_rsp_err`=0, `o_rsp_rdata`=0;
  - `o_mem_wren`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
- `o_mem_wren` is gated by `!i_rst`. A reset asserted during WRITE suppresses that write, and no response is issued.
- While `i_rst`=1, requests are ignored.
- `i_req_*` is sampled only at acceptance. Changes afterwards have no effect.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - halfword with `addr[0]`=1, or word with `addr[1:0]`!=0, is a fault;
  - the fault path gives err=1 at T+1 with no access.
- Undefined:
  - misaligned addresses are force-aligned (halfword clears `addr[0]`, word clears `addr[1:0]`);
  - the access proceeds normally with err=0;
  - range and funct3 faults still apply.

## Test plan
- Preload word 5 = 0x8899AABB. LB at 0x16 → rdata 0xFFFFFF99 at T+2. LBU at 0x16 → 0x00000099.
- SB of 0x11 to 0x15 over 0x8899AABB → word 5 = 0x889911BB after edge T+3. `o_mem_wren` is high for exactly one cycle.
- SW of 0xDEADBEEF to 0x20 → word 8 written at T+2. LH at 0x22 → 0xFFFFDEAD.
- LW at 0x00004000 (beyond MEMSIZE) → err=1 at T+1, rdata 0, no write.
- LH at 0x13:
  - with `LSU_MISALIGN_TRAP_EN`: err=1 at T+1;
  - without: reads halfword at 0x12, err=0.
- Assert `i_rst` during the WRITE cycle of an SB → memory word unchanged. After reset: `o_req_ready`=1, no `o_rsp_valid`.
